// File: rtl/riscv_single_cycle_cpu.sv
// riscv_single_cycle_cpu -- single-cycle RV32I integer core.
//
// One instruction retires on every rising clk edge. The core owns its
// instruction memory, register file and data memory; it has no external data
// ports. Programs are placed in DUT_instr.instruction_memory and results read
// from DUT_RF.RF and DUT_Data.data_memory through the hierarchy.
//
// Ports:
//   clk    system clock, all state commits on the rising edge
//   n_rst  synchronous reset, active HIGH despite the name: PC<=0, RF<=0 and
//          a one-edge recovery slot follows. Memory contents are kept.
//
// Sub-blocks: riscv_fetch (DUT_instr), riscv_regfile (DUT_RF),
// riscv_alu (DUT_ALU), riscv_control (DUT_Ctrl), riscv_dmem (DUT_Data).

package riscv_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
endpackage

// Instruction memory: combinational word read, indexed by PC[IA_W+1:2].
module riscv_fetch #(
   parameter int IMEM_WORDS = 256,
   parameter int IA_W       = $clog2(IMEM_WORDS)
) (
   input  logic [IA_W-1:0] addr,
   output logic [31:0]     instr
);
   logic [31:0] instruction_memory [0:IMEM_WORDS-1];

   assign instr = instruction_memory[addr];
endmodule

// 32x32 register file: two combinational read ports, one write port.
// x0 is never written and always reads as zero.
module riscv_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] RF [0:31];

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : RF[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : RF[ra2];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) RF[i] <= 32'd0;
      end else if (we && (wa != 5'd0)) begin
         RF[wa] <= wd;
      end
   end
endmodule

// Integer ALU; shifts use only the low five bits of b.
module riscv_alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] y
);
   import riscv_pkg::*;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      y = 32'd0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = a_s >>> b[4:0];
         ALU_SLT:  y = {31'd0, a_s < b_s};
         ALU_SLTU: y = {31'd0, a < b};
         default:  y = 32'd0;
      endcase
   end
endmodule

// Main decoder. Unknown opcodes leave every enable low, i.e. a NOP.
module riscv_control (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic       reg_we,
   output logic       mem_we,
   output logic       use_imm,
   output logic       a_is_pc,
   output logic       branch,
   output logic       jal,
   output logic       jalr,
   output logic [3:0] alu_op,
   output logic [1:0] wb_sel,
   output logic [2:0] imm_sel
);
   import riscv_pkg::*;
   logic alt;

   // funct7 = 0100000 selects sub (R-type only) and the arithmetic right shift.
   assign alt = (funct7 == 7'b0100000);

   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic a7,
                                             input logic is_reg);
      case (f3)
         3'b000:  return (a7 && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return a7 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_comb begin
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      use_imm = 1'b0;
      a_is_pc = 1'b0;
      branch  = 1'b0;
      jal     = 1'b0;
      jalr    = 1'b0;
      alu_op  = ALU_ADD;
      wb_sel  = WB_ALU;
      imm_sel = IMM_I;
      case (opcode)
         OP_R: begin
            reg_we = 1'b1;
            alu_op = alu_decode(funct3, alt, 1'b1);
         end
         OP_I: begin
            reg_we  = 1'b1;
            use_imm = 1'b1;
            alu_op  = alu_decode(funct3, alt, 1'b0);
         end
         OP_LOAD: begin
            reg_we  = 1'b1;
            use_imm = 1'b1;
            wb_sel  = WB_MEM;
         end
         OP_STORE: begin
            mem_we  = 1'b1;
            use_imm = 1'b1;
            imm_sel = IMM_S;
         end
         OP_LUI: begin
            reg_we  = 1'b1;
            wb_sel  = WB_IMM;
            imm_sel = IMM_U;
         end
         OP_AUIPC: begin
            reg_we  = 1'b1;
            a_is_pc = 1'b1;
            use_imm = 1'b1;
            imm_sel = IMM_U;
         end
         OP_BR: begin
            branch  = 1'b1;
            imm_sel = IMM_B;
         end
         OP_JAL: begin
            reg_we  = 1'b1;
            jal     = 1'b1;
            wb_sel  = WB_PC4;
            imm_sel = IMM_J;
         end
         OP_JALR: begin
            reg_we  = 1'b1;
            jalr    = 1'b1;
            use_imm = 1'b1;
            wb_sel  = WB_PC4;
         end
         default: ;
      endcase
   end
endmodule

// Data memory: combinational read, write on the rising edge.
module riscv_dmem #(
   parameter int DMEM_WORDS = 256,
   parameter int DA_W       = $clog2(DMEM_WORDS)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [DA_W-1:0] addr,
   input  logic [31:0]     wd,
   output logic [31:0]     rd
);
   logic [31:0] data_memory [0:DMEM_WORDS-1];

   assign rd = data_memory[addr];

   always_ff @(posedge clk) begin
      if (we) data_memory[addr] <= wd;
   end
endmodule

module riscv_single_cycle_cpu #(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 256
) (
   input  logic clk,
   input  logic n_rst
);
   import riscv_pkg::*;
   localparam int IA_W = $clog2(IMEM_WORDS);
   localparam int DA_W = $clog2(DMEM_WORDS);

   logic [31:0] PC;
   logic [31:0] instr;
   logic        recover;
   logic        commit;
   logic [31:0] imm, rs1_val, rs2_val, alu_a, alu_b, alu_y, mem_rdata, wb_data;
   logic [31:0] pc_plus4, pc_target, pc_next;
   logic        reg_we, mem_we, use_imm, a_is_pc, branch, jal, jalr, br_taken;
   logic [3:0]  alu_op;
   logic [1:0]  wb_sel;
   logic [2:0]  imm_sel;

   // Nothing architectural changes on a reset edge or on the recovery edge.
   assign commit = !n_rst && !recover;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         PC      <= 32'd0;
         recover <= 1'b1;
      end else if (recover) begin
         recover <= 1'b0;
      end else begin
         PC <= pc_next;
      end
   end

   riscv_fetch #(.IMEM_WORDS(IMEM_WORDS)) DUT_instr (
      .addr  (PC[IA_W+1:2]),
      .instr (instr)
   );

   riscv_control DUT_Ctrl (
      .opcode  (instr[6:0]),
      .funct3  (instr[14:12]),
      .funct7  (instr[31:25]),
      .reg_we  (reg_we),
      .mem_we  (mem_we),
      .use_imm (use_imm),
      .a_is_pc (a_is_pc),
      .branch  (branch),
      .jal     (jal),
      .jalr    (jalr),
      .alu_op  (alu_op),
      .wb_sel  (wb_sel),
      .imm_sel (imm_sel)
   );

   riscv_regfile DUT_RF (
      .clk (clk),
      .rst (n_rst),
      .we  (commit && reg_we),
      .ra1 (instr[19:15]),
      .ra2 (instr[24:20]),
      .wa  (instr[11:7]),
      .wd  (wb_data),
      .rd1 (rs1_val),
      .rd2 (rs2_val)
   );

   always_comb begin
      imm = 32'd0;
      case (imm_sel)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'd0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

   assign alu_a = a_is_pc ? PC : rs1_val;
   assign alu_b = use_imm ? imm : rs2_val;

   riscv_alu DUT_ALU (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .y  (alu_y)
   );

   riscv_dmem #(.DMEM_WORDS(DMEM_WORDS)) DUT_Data (
      .clk  (clk),
      .we   (commit && mem_we),
      .addr (alu_y[DA_W+1:2]),
      .wd   (rs2_val),
      .rd   (mem_rdata)
   );

   // Branch condition straight from funct3; reserved encodings never branch.
   always_comb begin
      br_taken = 1'b0;
      case (instr[14:12])
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_taken = (rs1_val <  rs2_val);
         3'b111:  br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4  = PC + 32'd4;
   assign pc_target = PC + imm;

   // jalr computes rs1+imm in the ALU; bit 0 of the target is forced to zero.
   always_comb begin
      pc_next = pc_plus4;
      if (jalr)
         pc_next = {alu_y[31:1], 1'b0};
      else if (jal || (branch && br_taken))
         pc_next = pc_target;
   end

   always_comb begin
      wb_data = alu_y;
      case (wb_sel)
         WB_MEM:  wb_data = mem_rdata;
         WB_PC4:  wb_data = pc_plus4;
         WB_IMM:  wb_data = imm;
         default: wb_data = alu_y;
      endcase
   end
endmodule

// File: tb/tb_riscv_single_cycle_cpu.sv
// Bench for riscv_single_cycle_cpu: directed programs from the test plan plus
// random straight-line programs compared against an instruction-level model.
module tb_riscv_single_cycle_cpu;
   logic clk = 1'b0;
   logic n_rst = 1'b1;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] prog [$];
   logic [31:0] mi  [0:255];
   logic [31:0] mr  [0:31];
   logic [31:0] mdm [0:255];
   logic [31:0] mpc;

   riscv_single_cycle_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk   (clk),
      .n_rst (n_rst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      return {imm20[19:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_j(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, 7'h13);
   endfunction

   // ---------------- reset / program load ----------------
   task automatic do_reset();
      n_rst = 1'b1;
      run(2);
   endtask

   // Reset, place prog at address 0 (rest NOP), reset the model, release reset.
   task automatic start_prog();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         dut.DUT_instr.instruction_memory[i] = 32'h0;
         mi[i] = 32'h0;
      end
      foreach (prog[i]) begin
         dut.DUT_instr.instruction_memory[i] = prog[i];
         mi[i] = prog[i];
      end
      for (int r = 0; r < 32; r++) mr[r] = 32'h0;
      mpc = 32'h0;
      n_rst = 1'b0;
   endtask

   // ---------------- instruction-level reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic iss_step();
      logic [31:0] w, a, b, res, npc, ea, imm_i, imm_s, imm_b, imm_u, imm_j;
      logic [2:0] f3;
      logic we, t;
      int rd;
      w     = mi[mpc[9:2]];
      f3    = w[14:12];
      rd    = int'(w[11:7]);
      a     = mr[w[19:15]];
      b     = mr[w[24:20]];
      imm_i = {{20{w[31]}}, w[31:20]};
      imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
      imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      imm_u = {w[31:12], 12'd0};
      imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      npc   = mpc + 4;
      we    = 1'b0;
      res   = 32'd0;
      case (w[6:0])
         7'h33: begin we = 1'b1; res = ref_alu(f3, w[30], a, b); end
         7'h13: begin we = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && w[30], a, imm_i); end
         7'h03: begin ea = a + imm_i; we = 1'b1; res = mdm[(ea >> 2) % 256]; end
         7'h23: begin ea = a + imm_s; mdm[(ea >> 2) % 256] = b; end
         7'h37: begin we = 1'b1; res = imm_u; end
         7'h17: begin we = 1'b1; res = mpc + imm_u; end
         7'h63: begin
            case (f3)
               3'd0:    t = (a == b);
               3'd1:    t = (a != b);
               3'd4:    t = ($signed(a) <  $signed(b));
               3'd5:    t = ($signed(a) >= $signed(b));
               3'd6:    t = (a <  b);
               3'd7:    t = (a >= b);
               default: t = 1'b0;
            endcase
            if (t) npc = mpc + imm_b;
         end
         7'h6f: begin we = 1'b1; res = mpc + 4; npc = mpc + imm_j; end
         7'h67: begin we = 1'b1; res = mpc + 4; npc = (a + imm_i) & ~32'd1; end
         default: ;
      endcase
      if (we && rd != 0) mr[rd] = res;
      mpc = npc;
   endtask

   // Word offsets 0..15 and -4..-1 (the latter wrap to words 252..255).
   function automatic int mem_off(input int k);
      return (k < 16) ? k * 4 : (k - 20) * 4;
   endfunction

   function automatic logic [31:0] rand_instr();
      int r_f3 [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
      int i_f3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
      int b_f3 [6]  = '{0, 1, 4, 5, 6, 7};
      int kind, sel, rd, rs1, rs2, imm;
      kind = int'($urandom_range(0, 9));
      rd   = int'($urandom_range(0, 7));
      rs1  = int'($urandom_range(0, 7));
      rs2  = int'($urandom_range(0, 7));
      case (kind)
         0, 1: begin
            sel = int'($urandom_range(0, 9));
            return enc_r((sel == 1 || sel == 7) ? 32 : 0, rs2, rs1, r_f3[sel], rd);
         end
         2, 3: begin
            sel = int'($urandom_range(0, 8));
            if (sel >= 6) imm = int'($urandom_range(0, 31)) | ((sel == 8) ? 32'h400 : 0);
            else          imm = int'($urandom_range(0, 4095));
            return enc_i(imm, rs1, i_f3[sel], rd, 7'h13);
         end
         4:  return enc_u(int'($urandom), rd, 7'h37);
         5:  return enc_u(int'($urandom), rd, 7'h17);
         6:  return enc_s(mem_off(int'($urandom_range(0, 19))) + int'($urandom_range(0, 3)), rs2, 0);
         7:  return enc_i(mem_off(int'($urandom_range(0, 19))) + int'($urandom_range(0, 3)), 0, 2, rd, 7'h03);
         8:  return enc_b($urandom_range(0, 1) ? 8 : 12, rs2, rs1, b_f3[$urandom_range(0, 5)]);
         default: return enc_j(8, rd);
      endcase
   endfunction

   initial begin
      // ---- Reset state ----
      do_reset();
      chk("reset pc", dut.PC, 32'd0);

      // ---- Arithmetic, recovery edge, mid-program reset ----
      prog = '{addi(1, 0, 10), addi(2, 0, 5), enc_r(0, 2, 1, 0, 3), enc_r(32, 2, 1, 0, 4)};
      start_prog();
      step();
      chk("recovery pc", dut.PC, 32'd0);
      chk("recovery x1", dut.DUT_RF.RF[1], 32'd0);
      run(6);
      chk("arith x1", dut.DUT_RF.RF[1], 32'd10);
      chk("arith x2", dut.DUT_RF.RF[2], 32'd5);
      chk("arith x3", dut.DUT_RF.RF[3], 32'd15);
      chk("arith x4", dut.DUT_RF.RF[4], 32'd5);
      chk("arith pc", dut.PC, 32'd24);

      start_prog();
      run(3);
      n_rst = 1'b1;
      step();
      chk("midrst pc", dut.PC, 32'd0);
      chk("midrst x1", dut.DUT_RF.RF[1], 32'd0);
      chk("midrst x3", dut.DUT_RF.RF[3], 32'd0);

      // ---- Memory ----
      prog = '{addi(1, 0, 100), enc_s(0, 1, 0), enc_i(0, 0, 2, 2, 7'h03), addi(3, 2, 1)};
      start_prog();
      run(7);
      chk("mem dmem0", dut.DUT_Data.data_memory[0], 32'd100);
      chk("mem x2", dut.DUT_RF.RF[2], 32'd100);
      chk("mem x3", dut.DUT_RF.RF[3], 32'd101);

      // ---- Loop ----
      prog = '{addi(1, 0, 0), addi(2, 0, 5), addi(1, 1, 1), enc_b(-4, 2, 1, 1)};
      start_prog();
      run(19);
      chk("loop x1", dut.DUT_RF.RF[1], 32'd5);
      chk("loop pc", dut.PC, 32'd40);

      // ---- Same-register chains ----
      prog = '{addi(1, 1, 1), addi(2, 2, 1), addi(1, 1, 1), addi(2, 2, 1),
               addi(1, 1, 1), addi(2, 2, 1), addi(1, 1, 1), addi(1, 1, 1)};
      start_prog();
      run(10);
      chk("same x1", dut.DUT_RF.RF[1], 32'd5);
      chk("same x2", dut.DUT_RF.RF[2], 32'd3);

      // ---- jal ----
      prog = '{enc_j(8, 1), addi(2, 0, 1), addi(3, 0, 2)};
      start_prog();
      run(5);
      chk("jal x1", dut.DUT_RF.RF[1], 32'd4);
      chk("jal x2", dut.DUT_RF.RF[2], 32'd0);
      chk("jal x3", dut.DUT_RF.RF[3], 32'd2);

      // ---- jalr ----
      prog = '{addi(6, 0, 12), enc_i(0, 6, 0, 5, 7'h67), addi(2, 0, 1), addi(3, 0, 2)};
      start_prog();
      run(5);
      chk("jalr x5", dut.DUT_RF.RF[5], 32'd8);
      chk("jalr x2", dut.DUT_RF.RF[2], 32'd0);
      chk("jalr x3", dut.DUT_RF.RF[3], 32'd2);

      // jalr with rd==rs1 and an odd target (bit 0 dropped)
      prog = '{addi(7, 0, 13), enc_i(0, 7, 0, 7, 7'h67), addi(2, 0, 1), addi(3, 0, 3)};
      start_prog();
      run(5);
      chk("jalr2 x7", dut.DUT_RF.RF[7], 32'd8);
      chk("jalr2 x2", dut.DUT_RF.RF[2], 32'd0);
      chk("jalr2 x3", dut.DUT_RF.RF[3], 32'd3);

      // ---- Reset between programs ----
      do_reset();
      chk("between x3", dut.DUT_RF.RF[3], 32'd0);
      chk("between x7", dut.DUT_RF.RF[7], 32'd0);

      // ---- Random programs, lockstep against the model ----
      for (int p = 0; p < 3; p++) begin
         prog = {};
         for (int k = 0; k < 20; k++) prog.push_back(enc_s(mem_off(k), 0, 0));
         for (int k = 0; k < 40; k++) prog.push_back(rand_instr());
         for (int i = 0; i < 256; i++) mdm[i] = 32'h0;
         start_prog();
         step();
         chk($sformatf("rnd%0d recovery pc", p), dut.PC, 32'd0);
         for (int e = 1; e < 70; e++) begin
            iss_step();
            step();
            chk($sformatf("rnd%0d pc edge%0d", p, e), dut.PC, mpc);
         end
         for (int r = 0; r < 32; r++)
            chk($sformatf("rnd%0d x%0d", p, r), dut.DUT_RF.RF[r], mr[r]);
         for (int k = 0; k < 20; k++)
            chk($sformatf("rnd%0d dmem%0d", p, (mem_off(k) >> 2) & 255),
                dut.DUT_Data.data_memory[(mem_off(k) >> 2) & 255], mdm[(mem_off(k) >> 2) & 255]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
